// File: rtl/kds_pkg.sv
// kds_pkg: shared types and constants for the KDS loader.
//   kds_loader_state_t : loader FSM states
//   KDS_NUM_GROUPS     : number of KDS FIFO groups (LE_select width)
//   KDS_FIFO_DEPTH     : slots per KDS FIFO
//   onehot_grp()       : group index -> one-hot load-enable
package kds_pkg;
  localparam int KDS_NUM_GROUPS = 12;
  localparam int KDS_FIFO_DEPTH = 8;
  localparam int KDS_GRP_W      = $clog2(KDS_NUM_GROUPS);

  typedef enum logic [1:0] {IDLE, COLLECT, SHIFT, RUN} kds_loader_state_t;

  function automatic logic [KDS_NUM_GROUPS-1:0] onehot_grp(input logic [KDS_GRP_W-1:0] idx);
    return KDS_NUM_GROUPS'(1) << idx;
  endfunction
endpackage

// File: rtl/kds_loader_if.sv
// kds_loader_if: word stream in plus the triplet/strobe bus out to the KDS bank.
//   din, din_valid, din_ready       : input word stream
//   v_1, v_2, v_3                   : triplet presented to the KDS FIFOs
//   LE_select, cycle_enable         : one-hot load-enable and shift strobe
//   master : stream source / KDS sink side
//   slave  : loader side
// Handshake: a word transfers on every rising clk edge where din_valid and
// din_ready are both high. The source holds din stable while din_valid is high
// and not yet accepted; din_ready does not depend on din_valid.
interface kds_loader_if
  import kds_pkg::*;
#(
  parameter int IO_DATA_WIDTH = 16,
  parameter int NUM_GROUPS    = KDS_NUM_GROUPS
);
  logic [IO_DATA_WIDTH-1:0] din;
  logic                     din_valid;
  logic                     din_ready;
  logic [IO_DATA_WIDTH-1:0] v_1;
  logic [IO_DATA_WIDTH-1:0] v_2;
  logic [IO_DATA_WIDTH-1:0] v_3;
  logic [NUM_GROUPS-1:0]    LE_select;
  logic                     cycle_enable;

  modport master (
    output din, din_valid,
    input  din_ready, v_1, v_2, v_3, LE_select, cycle_enable
  );

  modport slave (
    input  din, din_valid,
    output din_ready, v_1, v_2, v_3, LE_select, cycle_enable
  );
endinterface

// File: rtl/kds_triplet_packer.sv
// kds_triplet_packer: packs accepted stream words into v_1/v_2/v_3.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : restart the word count at v_1 (start of a load)
//   accept        : a word is transferred this cycle
//   din           : stream word
//   v_1..v_3      : capture registers, hold value until overwritten
//   triplet_full  : this accept completes the current triplet
module kds_triplet_packer #(
  parameter int IO_DATA_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     accept,
  input  logic [IO_DATA_WIDTH-1:0] din,
  output logic [IO_DATA_WIDTH-1:0] v_1,
  output logic [IO_DATA_WIDTH-1:0] v_2,
  output logic [IO_DATA_WIDTH-1:0] v_3,
  output logic                     triplet_full
);
  logic [1:0] word;

  assign triplet_full = accept && (word == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      word <= 2'd0;
      v_1  <= '0;
      v_2  <= '0;
      v_3  <= '0;
    end else if (clear) begin
      word <= 2'd0;
    end else if (accept) begin
      case (word)
        2'd0:    v_1 <= din;
        2'd1:    v_2 <= din;
        default: v_3 <= din;
      endcase
      word <= (word == 2'd2) ? 2'd0 : word + 2'd1;
    end
  end
endmodule

// File: rtl/kds_loader.sv
// kds_loader: sequences a word stream into the KDS FIFO groups, then runs the
// stored kernels for a programmed number of cycles.
//   clk, rst_in          : clock, synchronous active-high reset
//   start                : begin a load (IDLE only, wins over run_start)
//   run_start, run_len   : begin a run of run_len cycles (IDLE only)
//   bus (slave)          : din/din_valid/din_ready in; v_1..v_3, LE_select,
//                          cycle_enable out (all registered except din_ready)
//   busy                 : state is not IDLE
//   load_done, run_done  : one-cycle completion pulses
//   fsm_state            : current FSM state, for observation
module kds_loader
  import kds_pkg::*;
#(
  parameter int IO_DATA_WIDTH = 16,
  parameter int NUM_GROUPS    = KDS_NUM_GROUPS,
  parameter int FIFO_DEPTH    = KDS_FIFO_DEPTH,
  parameter int RUN_LEN_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_in,
  input  logic               start,
  input  logic               run_start,
  input  logic [RUN_LEN_WIDTH-1:0] run_len,
  kds_loader_if.slave        bus,
  output logic               busy,
  output logic               load_done,
  output logic               run_done,
  output kds_loader_state_t  fsm_state
);
  localparam int GRP_W  = $clog2(NUM_GROUPS);
  localparam int SLOT_W = $clog2(FIFO_DEPTH);

  kds_loader_state_t        state, state_n;
  logic [GRP_W-1:0]         grp, grp_n;
  logic [SLOT_W-1:0]        slot, slot_n;
  logic [RUN_LEN_WIDTH-1:0] cnt, cnt_n;
  logic [NUM_GROUPS-1:0]    le_q, le_n;
  logic                     ce_q, ce_n;
  logic                     load_done_n, run_done_n;
  logic                     clear, accept, triplet_full;

  assign bus.din_ready    = (state == COLLECT);
  assign busy             = (state != IDLE);
  assign fsm_state        = state;
  assign bus.LE_select    = le_q;
  assign bus.cycle_enable = ce_q;
  assign accept           = bus.din_valid && bus.din_ready;

  kds_triplet_packer #(.IO_DATA_WIDTH(IO_DATA_WIDTH)) u_packer (
    .clk          (clk),
    .rst          (rst_in),
    .clear        (clear),
    .accept       (accept),
    .din          (bus.din),
    .v_1          (bus.v_1),
    .v_2          (bus.v_2),
    .v_3          (bus.v_3),
    .triplet_full (triplet_full)
  );

  // Strobe outputs are registered, so they are computed for the state being
  // entered: the SHIFT strobe is set on the edge that captures the third word,
  // and a run's strobe is set on the edge that samples run_start.
  always_comb begin
    state_n     = state;
    grp_n       = grp;
    slot_n      = slot;
    cnt_n       = cnt;
    le_n        = '0;
    ce_n        = 1'b0;
    load_done_n = 1'b0;
    run_done_n  = 1'b0;
    clear       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = COLLECT;
          grp_n   = '0;
          slot_n  = '0;
          clear   = 1'b1;
        end else if (run_start) begin
          if (run_len == '0) begin
            // Zero-length run: no strobe, done on the next cycle.
            run_done_n = 1'b1;
          end else begin
            state_n = RUN;
            cnt_n   = run_len;
            ce_n    = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (triplet_full) begin
          state_n = SHIFT;
          ce_n    = 1'b1;
          le_n    = NUM_GROUPS'(onehot_grp(KDS_GRP_W'(grp)));
        end
      end
      SHIFT: begin
        state_n = COLLECT;
        if (slot == SLOT_W'(FIFO_DEPTH - 1)) begin
          slot_n = '0;
          if (grp == GRP_W'(NUM_GROUPS - 1)) begin
            state_n     = IDLE;
            grp_n       = '0;
            load_done_n = 1'b1;
          end else begin
            grp_n = grp + 1'b1;
          end
        end else begin
          slot_n = slot + 1'b1;
        end
      end
      RUN: begin
        // cnt holds the strobe cycles remaining including this one.
        if (cnt <= RUN_LEN_WIDTH'(1)) begin
          state_n    = IDLE;
          run_done_n = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
          ce_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state     <= IDLE;
      grp       <= '0;
      slot      <= '0;
      cnt       <= '0;
      le_q      <= '0;
      ce_q      <= 1'b0;
      load_done <= 1'b0;
      run_done  <= 1'b0;
    end else begin
      state     <= state_n;
      grp       <= grp_n;
      slot      <= slot_n;
      cnt       <= cnt_n;
      le_q      <= le_n;
      ce_q      <= ce_n;
      load_done <= load_done_n;
      run_done  <= run_done_n;
    end
  end
endmodule

// File: tb/tb_kds_loader.sv
// tb_kds_loader: directed sequence with randomized valid gaps, checked against
// a transaction-level model of the expected KDS loading order.
module tb_kds_loader;
  import kds_pkg::*;

  localparam int W      = 16;
  localparam int NG     = 12;
  localparam int FD     = 8;
  localparam int RLW    = 16;
  localparam int NSHIFT = FD * NG;
  localparam int NWORDS = 3 * NSHIFT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_in = 1'b1;
  logic           start = 1'b0;
  logic           run_start = 1'b0;
  logic [RLW-1:0] run_len = '0;
  logic           busy, load_done, run_done;
  kds_loader_state_t fsm_state;

  kds_loader_if #(.IO_DATA_WIDTH(W), .NUM_GROUPS(NG)) bus ();

  kds_loader #(.IO_DATA_WIDTH(W), .NUM_GROUPS(NG), .FIFO_DEPTH(FD), .RUN_LEN_WIDTH(RLW)) dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .start     (start),
    .run_start (run_start),
    .run_len   (run_len),
    .bus       (bus.slave),
    .busy      (busy),
    .load_done (load_done),
    .run_done  (run_done),
    .fsm_state (fsm_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc;
  logic [W-1:0] exp_q[$];     // words to send, in order
  logic [W-1:0] acc_q[$];     // words observed accepted
  logic [W-1:0] sh_v1_q[$], sh_v2_q[$], sh_v3_q[$];
  logic [NG-1:0] sh_le_q[$];
  int sh_cyc_q[$], sh_hs_q[$], ld_cyc_q[$], rd_cyc_q[$], run_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records observed transactions mid-cycle.
  always @(negedge clk) begin
    if (!rst_in) begin
      if (bus.cycle_enable && bus.LE_select != '0) begin
        sh_v1_q.push_back(bus.v_1);
        sh_v2_q.push_back(bus.v_2);
        sh_v3_q.push_back(bus.v_3);
        sh_le_q.push_back(bus.LE_select);
        sh_cyc_q.push_back(cyc);
        sh_hs_q.push_back(acc_q.size());
      end
      if (bus.cycle_enable && bus.LE_select == '0) run_cyc_q.push_back(cyc);
      if (bus.din_valid && bus.din_ready) acc_q.push_back(bus.din);
      if (load_done) ld_cyc_q.push_back(cyc);
      if (run_done) rd_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    acc_q.delete(); sh_v1_q.delete(); sh_v2_q.delete(); sh_v3_q.delete();
    sh_le_q.delete(); sh_cyc_q.delete(); sh_hs_q.delete();
    ld_cyc_q.delete(); rd_cyc_q.delete(); run_cyc_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic do_load(input bit rand_valid, input bit with_run, input int budget);
    int idx = 0;
    int n = 0;
    bit hs;
    clear_mon();
    bus.din       = exp_q[0];
    bus.din_valid = 1'b1;
    start         = 1'b1;
    run_start     = with_run;
    run_len       = RLW'(5);
    start_cyc     = cyc;
    while (ld_cyc_q.size() == 0 && n < budget) begin
      @(negedge clk);
      hs = bus.din_valid && bus.din_ready;
      tick();
      start     = 1'b0;
      run_start = with_run && (n == 40);
      if (hs) idx++;
      bus.din       = (idx < NWORDS) ? exp_q[idx] : '0;
      bus.din_valid = (idx < NWORDS) && (rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1);
      n++;
    end
    run_start = 1'b0;
    check("load_finished_in_budget", ld_cyc_q.size() != 0, 1);
    repeat (3) tick();
  endtask

  // Expected: triplet k holds words 3k..3k+2, group k/FD, and has seen 3(k+1) handshakes.
  task automatic verify_load(input bit timing);
    int m = 0;
    check("shift_count", sh_cyc_q.size(), NSHIFT);
    check("accepted_count", acc_q.size(), NWORDS);
    for (int i = 0; i < acc_q.size() && i < NWORDS; i++)
      if (acc_q[i] !== exp_q[i]) m++;
    check("accepted_order_errors", m, 0);
    for (int k = 0; k < sh_cyc_q.size() && k < NSHIFT; k++) begin
      check($sformatf("shift%0d_v1", k), sh_v1_q[k], exp_q[3*k]);
      check($sformatf("shift%0d_v2", k), sh_v2_q[k], exp_q[3*k+1]);
      check($sformatf("shift%0d_v3", k), sh_v3_q[k], exp_q[3*k+2]);
      check($sformatf("shift%0d_le", k), sh_le_q[k], longint'(1) << (k / FD));
      check($sformatf("shift%0d_handshakes", k), sh_hs_q[k], 3 * (k + 1));
    end
    check("load_done_once", ld_cyc_q.size(), 1);
    if (ld_cyc_q.size() > 0 && sh_cyc_q.size() > 0)
      check("load_done_cycle", ld_cyc_q[0], sh_cyc_q[$] + 1);
    if (timing && sh_cyc_q.size() > 0) begin
      check("first_shift_cycle", sh_cyc_q[0], start_cyc + 4);
      check("last_shift_cycle", sh_cyc_q[$], start_cyc + 4 * NSHIFT);
    end
  endtask

  task automatic do_run(input int len);
    int t;
    clear_mon();
    run_start = 1'b1;
    run_len   = RLW'(len);
    t = cyc;
    tick();
    run_start = 1'b0;
    @(negedge clk);
    check($sformatf("run%0d_busy_first", len), busy, len > 0);
    repeat (len + 4) tick();
    @(negedge clk);
    check($sformatf("run%0d_strobe_cycles", len), run_cyc_q.size(), len);
    if (len > 0 && run_cyc_q.size() > 0) begin
      check($sformatf("run%0d_first_strobe", len), run_cyc_q[0], t + 1);
      check($sformatf("run%0d_last_strobe", len), run_cyc_q[$], t + len);
    end
    check($sformatf("run%0d_done_count", len), rd_cyc_q.size(), 1);
    if (rd_cyc_q.size() > 0)
      check($sformatf("run%0d_done_cycle", len), rd_cyc_q[0], t + len + 1);
    check($sformatf("run%0d_no_shift", len), sh_cyc_q.size(), 0);
    check($sformatf("run%0d_busy_end", len), busy, 0);
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    bus.din       = '0;
    bus.din_valid = 1'b1;
    rst_in        = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_v1", bus.v_1, 0);
    check("rst_v2", bus.v_2, 0);
    check("rst_v3", bus.v_3, 0);
    check("rst_le", bus.LE_select, 0);
    check("rst_ce", bus.cycle_enable, 0);
    check("rst_ready", bus.din_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_load_done", load_done, 0);
    check("rst_run_done", run_done, 0);
    check("rst_state", fsm_state, IDLE);
    tick();
    rst_in        = 1'b0;
    bus.din_valid = 1'b0;
    tick();

    // Full load, valid held high, words 0..287.
    exp_q.delete();
    for (int i = 0; i < NWORDS; i++) exp_q.push_back(W'(i));
    do_load(1'b0, 1'b0, 4000);
    verify_load(1'b1);
    @(negedge clk);
    check("hold_v1_after_load", bus.v_1, 285);
    check("hold_v3_after_load", bus.v_3, 287);
    check("idle_after_load", busy, 0);
    tick();

    // Same words with random valid gaps, start+run_start together, and a
    // run_start pulse mid-load: neither run request may take effect.
    do_load(1'b1, 1'b1, 4000);
    verify_load(1'b0);
    check("priority_no_run_strobe", run_cyc_q.size(), 0);
    check("priority_no_run_done", rd_cyc_q.size(), 0);

    do_run(5);
    do_run(0);

    // Reset after two words of the first triplet, then restart.
    clear_mon();
    start         = 1'b1;
    bus.din       = W'(500);
    bus.din_valid = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bus.din = W'(501);
    tick();
    rst_in  = 1'b1;
    bus.din = W'(502);
    tick();
    rst_in = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_v1", bus.v_1, 0);
    check("midrst_ready", bus.din_ready, 0);
    tick();
    clear_mon();
    start         = 1'b1;
    bus.din       = W'(100);
    bus.din_valid = 1'b1;
    n = 0;
    while (sh_cyc_q.size() == 0 && n < 20) begin
      tick();
      start = 1'b0;
      if (acc_q.size() < 3) bus.din = W'(100 + acc_q.size());
      else bus.din_valid = 1'b0;
      n++;
    end
    check("midrst_shift_seen", sh_cyc_q.size(), 1);
    if (sh_cyc_q.size() > 0) begin
      check("midrst_v1_new", sh_v1_q[0], 100);
      check("midrst_v2_new", sh_v2_q[0], 101);
      check("midrst_v3_new", sh_v3_q[0], 102);
      check("midrst_le_new", sh_le_q[0], 1);
    end
    bus.din_valid = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
